// File: rtl/dz_scan_ctrl_if.sv
// Bus between the counter logic and the dot-matrix scan controller:
// digit/colour load on one side, matrix row/column drive on the other.
interface dz_scan_ctrl_if;
  logic [3:0] num;
  logic [1:0] color;
  logic       load;
  logic       blink;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic       frame_start;

  modport master (
    output num, color, load, blink,
    input  row, colr, colg, frame_start
  );

  modport slave (
    input  num, color, load, blink,
    output row, colr, colg, frame_start
  );
endinterface

// File: rtl/dz_scan_ctrl.sv
// 8x8 bicolour dot-matrix row-scan controller with frame-synchronous glyph update.
// Optional blinking is built only when DZ_BLINK_EN is defined.
module dz_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 32,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  dz_scan_ctrl_if.slave bus
);

  localparam int         DIV_W    = $clog2(SCAN_DIV);
  localparam logic [7:0] ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] color;
    logic       blink;
  } disp_t;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [2:0]       row_idx, row_nxt;
  logic             run;
  logic             div_end, frame_end, dark;
  disp_t            pend, pend_nxt, shadow, shadow_nxt;
  logic [7:0]       pattern, row_sel, row_pins, colr_nxt, colg_nxt;
  logic             show;

  function automatic logic [7:0] font_row(input logic [3:0] n, input logic [2:0] r);
    logic [63:0] g;
    int          idx;
    case (n)
      4'd0:    g = 64'h00_3C_42_42_42_42_42_3C;
      4'd1:    g = 64'h00_18_18_38_18_18_18_7E;
      4'd2:    g = 64'h00_3C_66_06_0C_30_60_7E;
      4'd3:    g = 64'h00_3C_66_06_1C_06_66_3C;
      4'd4:    g = 64'h00_0C_1C_2C_4C_7E_0C_0C;
      4'd5:    g = 64'h00_7E_60_7C_06_06_66_3C;
      4'd6:    g = 64'h00_3C_60_7C_66_66_66_3C;
      4'd7:    g = 64'h00_7E_06_0C_18_30_30_30;
      4'd8:    g = 64'h00_3C_66_66_3C_66_66_3C;
      4'd9:    g = 64'h00_3C_66_66_3E_06_06_3C;
      default: g = 64'h0;
    endcase
    idx = 63 - 8 * int'(r);
    return g[idx -: 8];
  endfunction

  // Outputs are registered from next-state counters so the pins track div_cnt/row_idx
  // with no visible lag; the first edge after reset only arms the scan.
  always_comb begin
    div_end    = run && (div_cnt == DIV_W'(SCAN_DIV - 1));
    frame_end  = div_end && (row_idx == 3'd7);
    div_nxt    = !run ? div_cnt : (div_end ? '0 : div_cnt + DIV_W'(1));
    row_nxt    = div_end ? row_idx + 3'd1 : row_idx;
    pend_nxt   = bus.load ? disp_t'{bus.num, bus.color, bus.blink} : pend;
    shadow_nxt = frame_end ? pend_nxt : shadow;
    pattern    = font_row(shadow_nxt.num, row_nxt);
    show       = !dark && (div_nxt != '0);
    row_sel    = 8'b1 << row_nxt;
    row_pins   = (div_nxt == '0) ? ROW_IDLE : (ROW_ACTIVE_LOW ? ~row_sel : row_sel);
    colr_nxt   = (show && shadow_nxt.color[0]) ? pattern : 8'h00;
    colg_nxt   = (show && shadow_nxt.color[1]) ? pattern : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt         <= '0;
      row_idx         <= '0;
      run             <= 1'b0;
      pend            <= '0;
      shadow          <= '0;
      bus.row         <= ROW_IDLE;
      bus.colr        <= 8'h00;
      bus.colg        <= 8'h00;
      bus.frame_start <= 1'b0;
    end else begin
      div_cnt         <= div_nxt;
      row_idx         <= row_nxt;
      run             <= 1'b1;
      pend            <= pend_nxt;
      shadow          <= shadow_nxt;
      bus.row         <= row_pins;
      bus.colr        <= colr_nxt;
      bus.colg        <= colg_nxt;
      bus.frame_start <= (div_nxt == '0) && (row_nxt == 3'd0);
    end
  end

`ifdef DZ_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;
  logic            phase, phase_nxt, cnt_wrap;

  always_comb begin
    cnt_wrap  = frame_end && (frame_cnt == FC_W'(BLINK_FRAMES - 1));
    phase_nxt = phase ^ cnt_wrap;
    dark      = shadow_nxt.blink && phase_nxt;
  end

  // Phase flips once every BLINK_FRAMES frames, giving the blink half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (frame_end)
        frame_cnt <= cnt_wrap ? '0 : frame_cnt + FC_W'(1);
    end
  end
`else
  logic unused_blink;

  assign dark         = 1'b0;
  assign unused_blink = shadow_nxt.blink ^ (BLINK_FRAMES > 0);
`endif

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Directed table-driven bench for dz_scan_ctrl at SCAN_DIV=4, BLINK_FRAMES=2.
module tb_dz_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   pos   = 0;

  dz_scan_ctrl_if bus();

  dz_scan_ctrl #(
    .SCAN_DIV      (4),
    .BLINK_FRAMES  (2),
    .ROW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] num;
    logic [1:0] color;
    int         row_i;
    int         div_i;
    logic [7:0] exp_row;
    logic [7:0] exp_colr;
    logic [7:0] exp_colg;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % 32;
    end
  endtask

  task automatic step_to(input int target);
    step((target - pos + 32) % 32);
  endtask

  task automatic apply_stimulus(input logic [3:0] n, input logic [1:0] c, input logic b);
    bus.num   = n;
    bus.color = c;
    bus.blink = b;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (!bus.frame_start && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.frame_start) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: frame_start got 0 expected 1 within 40 cycles", name);
    end
    pos = 0;
  endtask

  initial begin
    logic dark;

    vecs[0]  = '{4'd2,  2'd3, 1, 0, 8'hFF, 8'h00, 8'h00};
    vecs[1]  = '{4'd2,  2'd3, 1, 1, 8'hFD, 8'h3C, 8'h3C};
    vecs[2]  = '{4'd2,  2'd3, 1, 3, 8'hFD, 8'h3C, 8'h3C};
    vecs[3]  = '{4'd4,  2'd1, 5, 2, 8'hDF, 8'h7E, 8'h00};
    vecs[4]  = '{4'd4,  2'd1, 0, 1, 8'hFE, 8'h00, 8'h00};
    vecs[5]  = '{4'd7,  2'd2, 7, 1, 8'h7F, 8'h00, 8'h30};
    vecs[6]  = '{4'd12, 2'd3, 3, 2, 8'hF7, 8'h00, 8'h00};
    vecs[7]  = '{4'd9,  2'd3, 4, 3, 8'hEF, 8'h3E, 8'h3E};
    vecs[8]  = '{4'd0,  2'd0, 2, 1, 8'hFB, 8'h00, 8'h00};
    vecs[9]  = '{4'd8,  2'd1, 6, 2, 8'hBF, 8'h66, 8'h00};
    vecs[10] = '{4'd15, 2'd1, 0, 0, 8'hFF, 8'h00, 8'h00};
    vecs[11] = '{4'd5,  2'd2, 3, 1, 8'hF7, 8'h00, 8'h7C};

    bus.num   = 4'd0;
    bus.color = 2'd0;
    bus.blink = 1'b0;
    bus.load  = 1'b0;
    rst_n     = 1'b0;

    // Reset held for five cycles, then release and frame_start cadence.
    repeat (5) @(posedge clk);
    #1;
    check_output("reset row", bus.row, 8'hFF);
    check_output("reset colr", bus.colr, 8'h00);
    check_output("reset colg", bus.colg, 8'h00);
    check_output("reset frame_start", {7'd0, bus.frame_start}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pos = 0;
    check_output("first frame_start", {7'd0, bus.frame_start}, 8'h01);
    step(1);
    check_output("frame_start low", {7'd0, bus.frame_start}, 8'h00);
    step_to(0);
    check_output("frame_start period", {7'd0, bus.frame_start}, 8'h01);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].num, vecs[i].color, 1'b0);
      wait_frame($sformatf("vec%0d frame", i));
      step_to(4 * vecs[i].row_i + vecs[i].div_i);
      check_output($sformatf("vec%0d row", i), bus.row, vecs[i].exp_row);
      check_output($sformatf("vec%0d colr", i), bus.colr, vecs[i].exp_colr);
      check_output($sformatf("vec%0d colg", i), bus.colg, vecs[i].exp_colg);
      check_output($sformatf("vec%0d frame_start", i), {7'd0, bus.frame_start},
                   {7'd0, (vecs[i].row_i == 0 && vecs[i].div_i == 0)});
    end

    // Tearing: a load in row 3 must not reach rows 4-7 of the same frame.
    apply_stimulus(4'd8, 2'd2, 1'b0);
    wait_frame("tear setup");
    step_to(13);
    apply_stimulus(4'd1, 2'd2, 1'b0);
    step_to(29);
    check_output("tear old glyph", bus.colg, 8'h3C);
    wait_frame("tear next frame");
    step_to(29);
    check_output("tear new glyph", bus.colg, 8'h7E);

    // Bypass: a load on the wrap edge shows in the frame it starts.
    step_to(31);
    apply_stimulus(4'd8, 2'd2, 1'b0);
    check_output("bypass frame_start", {7'd0, bus.frame_start}, 8'h01);
    step_to(9);
    check_output("bypass glyph", bus.colg, 8'h66);

    // Reset pulsed mid-row 5 acts immediately.
    step_to(22);
    rst_n = 1'b0;
    #1;
    check_output("midreset row", bus.row, 8'hFF);
    check_output("midreset colg", bus.colg, 8'h00);
    check_output("midreset frame_start", {7'd0, bus.frame_start}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pos = 0;
    check_output("midreset restart", {7'd0, bus.frame_start}, 8'h01);

    // Blink: frames counted from reset; frames 2-3 dark when blinking is built in.
    apply_stimulus(4'd3, 2'd3, 1'b1);
    for (int f = 0; f < 6; f++) begin
      step_to(5);
`ifdef DZ_BLINK_EN
      dark = (f == 2 || f == 3);
`else
      dark = 1'b0;
`endif
      check_output($sformatf("blink f%0d row", f), bus.row, 8'hFD);
      check_output($sformatf("blink f%0d colr", f), bus.colr,
                   (f == 0 || dark) ? 8'h00 : 8'h3C);
      step_to(0);
      check_output($sformatf("blink f%0d frame_start", f), {7'd0, bus.frame_start}, 8'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dz_scan_ctrl.md
# dz_scan_ctrl

Parametrised 8x8 bicolour (red/green) dot-matrix scan controller for the `dz_count` display path. It latches a 4-bit digit code (0-9) and a 2-bit colour, then row-scans the matrix with a programmable dwell per row. Each row slot starts with a one-cycle blanking interval, and the displayed glyph updates only at frame boundaries so a digit is never torn. It sits between the counter logic and the matrix pins, and supersedes the fixed 0-5 red/green/yellow digit display.

## Interface
- `SCAN_DIV`, 1000: clock cycles per row slot; must be ≥ 2.
- `BLINK_FRAMES`, 32: frames per blink half-period; must be ≥ 1; used only with `DZ_BLINK_EN`.
- `ROW_ACTIVE_LOW`, 1: 1 means the selected row is driven 0 and idle rows 1; 0 inverts this.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `num` in 4: digit code; 0-9 are glyphs, 10-15 are blank.
- `color` in 2: 0 = off, 1 = red, 2 = green, 3 = yellow (red and green).
- `load` in 1: one-cycle strobe that captures `num`, `color` and `blink`.
- `blink` in 1: blink request, captured with `load`.
- `row` out 8: row select; bit i selects row i, with row 0 at the top.
- `colr` out 8: red columns, active-high; MSB is the leftmost column.
- `colg` out 8: green columns, same layout as `colr`.
- `frame_start` out 1: one-cycle pulse in the first cycle of row 0.

## Operation
- **Counters:**
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `row_idx` counts 0..7; it increments (mod 8) on the edge where `div_cnt == SCAN_DIV-1`.
- **Pending register:** `load` = 1 writes {num, color, blink} into pending.
- **Shadow register:**
  - Shadow is the displayed value; it is copied from pending on the wrap edge (`row_idx` 7→0).
  - If `load` coincides with the wrap edge, shadow takes the new input values directly (bypass), and pending is also updated.
- **Font (hex, rows 0..7):**
  - 0: 00 3C 42 42 42 42 42 3C
  - 1: 00 18 18 38 18 18 18 7E
  - 2: 00 3C 66 06 0C 30 60 7E
  - 3: 00 3C 66 06 1C 06 66 3C
  - 4: 00 0C 1C 2C 4C 7E 0C 0C
  - 5: 00 7E 60 7C 06 06 66 3C
  - 6: 00 3C 60 7C 66 66 66 3C
  - 7: 00 7E 06 0C 18 30 30 30
  - 8: 00 3C 66 66 3C 66 66 3C
  - 9: 00 3C 66 66 3E 06 06 3C
  - 10-15: all rows 00.
- **Colour mapping:**
  - `colr` = pattern when colour is 1 or 3, else 00.
  - `colg` = pattern when colour is 2 or 3, else 00.
- **Blanking:** while `div_cnt == 0`, `row` is all inactive and `colr`/`colg` are 00.
- **Active drive:** while `div_cnt` is 1..SCAN_DIV-1, only the `row` bit for `row_idx` is active, and the columns show the shadow glyph row `row_idx`.
- **Reset values:**
  - `div_cnt` = 0, `row_idx` = 0.
  - Pending and shadow = {num 0, colour 0, blink 0}.
  - `row` = all inactive (FF when `ROW_ACTIVE_LOW` = 1, otherwise 00).
  - `colr` = `colg` = 00, `frame_start` = 0, blink phase = 0.
- **Reset mid-frame:** asserting reset mid-frame returns everything to the reset values immediately; the scan restarts at row 0.

## Timing
- `row`, `colr`, `colg` and `frame_start` are registered outputs.
- Output values are a function of the current `div_cnt`/`row_idx` as defined above; there is no extra pipeline stage visible at the pins.
- `frame_start` = 1 exactly when `row_idx == 0` and `div_cnt == 0`, including the first cycle after reset release.
- Frame length is 8·SCAN_DIV cycles.
- A `load` not on the wrap edge becomes visible at the next `frame_start`; a `load` on the wrap edge is visible in that same frame.
- Multiple `load`s within one frame: the last one wins.

## Configuration
- **`DZ_BLINK_EN` defined:**
  - A frame counter counts wrap edges 0..BLINK_FRAMES-1.
  - Blink phase toggles each time that counter wraps.
  - While shadow blink = 1 and phase = 1, `colr`/`colg` are forced to 00; rows keep scanning.
- **`DZ_BLINK_EN` not defined:** the `blink` port exists but is ignored, no frame counter is built, and the glyph is always shown.

## Test plan
- **Reset:** hold `rst_n` = 0 for 5 cycles at SCAN_DIV = 4 → `row` = FF, `colr` = `colg` = 00. After release, `frame_start` = 1 in the first cycle and again every 32 cycles.
- **Digit 2, yellow:** `load` num = 2, colour = 3, then wait for the wrap. In the row-1 slot: cycle 0 has `row` = FF and columns 00; cycles 1-3 have `row` = FD and `colr` = `colg` = 3C.
- **Digit 4, red:** `load` num = 4, colour = 1. Row 5 → `colr` = 7E, `colg` = 00; row 0 → both 00.
- **Tearing and bypass:**
  - `load` num = 1 during row 3 → rows 4-7 still show the old glyph; the next frame shows 1 (row 7, green: `colg` = 7E).
  - `load` num = 8 exactly on the wrap edge → 8 is shown in that frame.
- **Blank code:** `load` num = 12, colour = 3 → `row` keeps scanning with `colr` = `colg` = 00.
- **Blink:**
  - With `DZ_BLINK_EN`, BLINK_FRAMES = 2, blink = 1: frames 0-1 visible, frames 2-3 dark, frames 4-5 visible.
  - Without the macro: all frames visible.
  - `rst_n` pulsed mid-row 5 → outputs reset at once; the next `frame_start` occurs on the first cycle after release.
